// File: rtl/cyberrio_bus_pkg.sv
// Shared types and constants for the ext_* to Wishbone B4 classic master bridge.
package cyberrio_bus_pkg;

  localparam int WORD_BYTES = 4;
  localparam logic [WORD_BYTES-1:0] SEL_ALL = 4'hF;
  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } bridge_state_e;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0] address;
    logic [BUS_DATA_W-1:0] data;
    logic [WORD_BYTES-1:0] sel;
    logic                  we;
    logic                  fetch;
  } bus_req_t;

endpackage

// File: rtl/ext_wb_timeout_counter.sv
// Wait-state counter for the bridge; expired pulses on the last allowed wait cycle.
module ext_wb_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int RAW_W = $clog2(LIMIT + 1);
  localparam int CNT_W = (RAW_W < 8) ? 8 : ((RAW_W > 16) ? 16 : RAW_W);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // count_q holds the number of completed wait cycles, so the limit is hit one below LIMIT
  assign expired = enable && (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/ext_wb_master_bridge.sv
// ext_* valid/ready port to Wishbone B4 classic master, single outstanding access.
// Optional wait-state timeout enabled with `define EXT_WB_TIMEOUT_EN.
module ext_wb_master_bridge
  import cyberrio_bus_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ext_valid,
  input  logic                ext_instruction,
  input  logic [ADDR_W-1:0]   ext_address,
  input  logic [DATA_W-1:0]   ext_write_data,
  input  logic [DATA_W/8-1:0] ext_write_strobe,
  output logic                ext_ready,
  output logic [DATA_W-1:0]   ext_read_data,
  output logic                ext_error,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [DATA_W-1:0]   wbm_dat_o,
  input  logic [DATA_W-1:0]   wbm_dat_i,
  input  logic                wbm_ack_i,
  input  logic                wbm_err_i,
  output logic                fetch_tag_o
);

  localparam int LSB_W = $clog2(WORD_BYTES);

  bridge_state_e     state_q;
  bus_req_t          req_q;
  bus_req_t          req_d;
  logic              cyc_q;
  logic              ready_q;
  logic              error_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] rdata_q;
  logic              bus_done;
  logic              timeout;

  always_comb begin
    req_d         = '0;
    req_d.address = BUS_ADDR_W'({ext_address[ADDR_W-1:LSB_W], {LSB_W{1'b0}}});
    req_d.data    = ext_write_data;
    req_d.we      = |ext_write_strobe;
    req_d.sel     = req_d.we ? ext_write_strobe : SEL_ALL;
    req_d.fetch   = ext_instruction;
  end

  assign bus_done = wbm_ack_i | wbm_err_i;

`ifdef EXT_WB_TIMEOUT_EN
  ext_wb_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != BUS),
    .enable ((state_q == BUS) && !bus_done),
    .expired(timeout)
  );
`else
  logic unused_timeout_cfg;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      req_q      <= '0;
      cyc_q      <= 1'b0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      resp_err_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ext_valid) begin
            req_q   <= req_d;
            cyc_q   <= 1'b1;
            state_q <= BUS;
          end
        end
        BUS: begin
          // a completion wins over a timeout raised in the same cycle
          if (bus_done || timeout) begin
            cyc_q      <= 1'b0;
            resp_err_q <= wbm_err_i || !bus_done;
            rdata_q    <= (wbm_err_i || !bus_done || req_q.we) ? '0 : wbm_dat_i;
            state_q    <= DONE;
          end
        end
        DONE: begin
          // two-phase DONE: first cycle registers the pulse, second cycle shows it,
          // so ext_valid still held during the pulse is never mistaken for a new request
          if (!ready_q) begin
            ready_q <= 1'b1;
            error_q <= resp_err_q;
          end else begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^ext_address[LSB_W-1:0];

  assign wbm_cyc_o     = cyc_q;
  assign wbm_stb_o     = cyc_q;
  assign wbm_we_o      = req_q.we;
  assign wbm_sel_o     = req_q.sel;
  assign wbm_adr_o     = req_q.address[ADDR_W-1:0];
  assign wbm_dat_o     = req_q.data;
  assign fetch_tag_o   = req_q.fetch;
  assign ext_ready     = ready_q;
  assign ext_error     = error_q;
  assign ext_read_data = rdata_q;

endmodule

// File: tb/tb_ext_wb_master_bridge.sv
// Randomized bench for ext_wb_master_bridge against a transaction-level timing/value model.
module tb_ext_wb_master_bridge;

  localparam int TO     = 8;
  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_BOTH = 2;
  localparam int M_NONE = 3;
`ifdef EXT_WB_TIMEOUT_EN
  localparam int HANG = 2;
  localparam int WMAX = TO - 1;
`else
  localparam int HANG = 1000;
  localparam int WMAX = 5;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ext_valid = 1'b0;
  logic        ext_instruction = 1'b0;
  logic [31:0] ext_address = '0;
  logic [31:0] ext_write_data = '0;
  logic [3:0]  ext_write_strobe = '0;
  logic        ext_ready;
  logic [31:0] ext_read_data;
  logic        ext_error;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;
  logic        fetch_tag_o;

  ext_wb_master_bridge #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .ext_valid       (ext_valid),
    .ext_instruction (ext_instruction),
    .ext_address     (ext_address),
    .ext_write_data  (ext_write_data),
    .ext_write_strobe(ext_write_strobe),
    .ext_ready       (ext_ready),
    .ext_read_data   (ext_read_data),
    .ext_error       (ext_error),
    .wbm_cyc_o       (wbm_cyc_o),
    .wbm_stb_o       (wbm_stb_o),
    .wbm_we_o        (wbm_we_o),
    .wbm_sel_o       (wbm_sel_o),
    .wbm_adr_o       (wbm_adr_o),
    .wbm_dat_o       (wbm_dat_o),
    .wbm_dat_i       (wbm_dat_i),
    .wbm_ack_i       (wbm_ack_i),
    .wbm_err_i       (wbm_err_i),
    .fetch_tag_o     (fetch_tag_o)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // model of the single outstanding transaction: bus window, ready cycle, values
  bit          m_active = 1'b0;
  int          m_cs = 0, m_ce = 0, m_rdy = 0;
  logic [31:0] m_adr = '0, m_dat = '0, m_rd = '0;
  logic [3:0]  m_sel = '0;
  logic        m_we = 1'b0, m_fetch = 1'b0, m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic set_model(input int vc, input int w_eff, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb,
                           input logic fetch, input logic err, input logic [31:0] sdata);
    m_cs    = vc + 1;
    m_ce    = vc + 1 + w_eff;
    m_rdy   = vc + 3 + w_eff;
    m_adr   = {addr[31:2], 2'b00};
    m_we    = (strb != 4'h0);
    m_sel   = m_we ? strb : 4'hF;
    m_dat   = data;
    m_fetch = fetch;
    m_err   = err;
    m_rd    = (err || m_we) ? 32'h0 : sdata;
    m_active = 1'b1;
  endtask

  initial begin
    bit e_cyc, e_rdy;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e_cyc = m_active && (cyc_n >= m_cs) && (cyc_n <= m_ce);
        e_rdy = m_active && (cyc_n == m_rdy);
        check("cyc", 32'(wbm_cyc_o), 32'(e_cyc));
        check("stb", 32'(wbm_stb_o), 32'(e_cyc));
        check("ready", 32'(ext_ready), 32'(e_rdy));
        if (e_cyc) begin
          check("adr", wbm_adr_o, m_adr);
          check("sel", 32'(wbm_sel_o), 32'(m_sel));
          check("we", 32'(wbm_we_o), 32'(m_we));
          check("dat_o", wbm_dat_o, m_dat);
          check("fetch_tag", 32'(fetch_tag_o), 32'(m_fetch));
        end
        if (e_rdy) begin
          check("read_data", ext_read_data, m_rd);
          check("error", 32'(ext_error), 32'(m_err));
        end else begin
          check("error_idle", 32'(ext_error), 32'h0);
        end
      end
    end
  end

  task automatic do_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input logic fetch, input int w, input int mode, input logic [31:0] sdata,
                        output int lat, output int rdy_cyc, output int first_stb,
                        output logic [31:0] rd, output logic er, output logic [31:0] c_adr,
                        output logic [3:0] c_sel, output logic c_we);
    int vc, stb_seen;
    bit got;
    @(posedge clk); #1;
    ext_valid        = 1'b1;
    ext_address      = addr;
    ext_write_data   = data;
    ext_write_strobe = strb;
    ext_instruction  = fetch;
    vc = cyc_n;
    set_model(vc, (mode == M_NONE) ? TO - 1 : w, addr, data, strb, fetch, mode != M_ACK, sdata);
    stb_seen = 0; got = 1'b0; lat = -1; rdy_cyc = -1; first_stb = -1;
    rd = '0; er = 1'b0; c_adr = '0; c_sel = '0; c_we = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(posedge clk); #1;
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      wbm_dat_i = $urandom;
      if (ext_ready) begin
        got = 1'b1; lat = cyc_n - vc; rdy_cyc = cyc_n;
        rd = ext_read_data; er = ext_error;
      end else if (wbm_cyc_o) begin
        if (stb_seen == 0) begin
          first_stb = cyc_n; c_adr = wbm_adr_o; c_sel = wbm_sel_o; c_we = wbm_we_o;
        end
        if (stb_seen == w && mode != M_NONE) begin
          wbm_ack_i = (mode != M_ERR);
          wbm_err_i = (mode != M_ACK);
          wbm_dat_i = sdata;
        end
        stb_seen++;
      end else begin
        wbm_ack_i = ($urandom_range(0, 3) == 0);
        wbm_err_i = ($urandom_range(0, 3) == 0);
      end
    end
    check("ready_seen", 32'(got), 32'h1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ext_valid        = 1'b0;
      ext_address      = $urandom;
      ext_write_strobe = 4'($urandom);
      wbm_ack_i        = ($urandom_range(0, 3) == 0);
      wbm_err_i        = ($urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rc, fs, rc1, k, w, mode, vc;
    logic [31:0] rd, ca, a, d, sd;
    logic er, cw, f;
    logic [3:0] cs, s;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ext_ready), 32'h0);
    check("rst_error", 32'(ext_error), 32'h0);
    check("rst_rdata", ext_read_data, 32'h0);
    check("rst_cyc", 32'(wbm_cyc_o), 32'h0);
    check("rst_stb", 32'(wbm_stb_o), 32'h0);
    check("rst_we", 32'(wbm_we_o), 32'h0);
    check("rst_sel", 32'(wbm_sel_o), 32'h0);
    check("rst_adr", wbm_adr_o, 32'h0);
    check("rst_dat", wbm_dat_o, 32'h0);
    check("rst_fetch", 32'(fetch_tag_o), 32'h0);
    reset = 1'b0;
    chk_en = 1'b1;
    idle(2);

    do_txn(32'h0000_1006, 32'h0, 4'h0, 1'b0, 0, M_ACK, 32'hDEAD_BEEF, lat, rc, fs, rd, er, ca, cs, cw);
    check("t1_latency", 32'(lat), 32'd3);
    check("t1_rdata", rd, 32'hDEAD_BEEF);
    check("t1_error", 32'(er), 32'h0);
    check("t1_adr", ca, 32'h0000_1004);
    check("t1_sel", 32'(cs), 32'hF);
    check("t1_we", 32'(cw), 32'h0);
    idle(1);

    do_txn(32'h20, 32'h1234_5678, 4'b0011, 1'b0, 2, M_ACK, 32'hCAFE_F00D, lat, rc, fs, rd, er, ca, cs, cw);
    check("t2_latency", 32'(lat), 32'd5);
    check("t2_rdata", rd, 32'h0);
    check("t2_we", 32'(cw), 32'h1);
    check("t2_sel", 32'(cs), 32'h3);
    idle(1);

    do_txn(32'h400, 32'h0, 4'h0, 1'b1, 0, M_BOTH, 32'h55AA_55AA, lat, rc, fs, rd, er, ca, cs, cw);
    check("t3_error", 32'(er), 32'h1);
    check("t3_rdata", rd, 32'h0);
    check("t3_latency", 32'(lat), 32'd3);

    do_txn(32'h100, 32'h0, 4'h0, 1'b0, 1, M_ACK, 32'h0BAD_F00D, lat, rc1, fs, rd, er, ca, cs, cw);
    do_txn(32'h104, 32'hA5A5_0001, 4'hF, 1'b0, 0, M_ACK, 32'h1111_2222, lat, rc, fs, rd, er, ca, cs, cw);
    check("b2b_gap", 32'((fs - rc1) >= 2), 32'h1);
    check("b2b_latency", 32'(lat), 32'd3);
    idle(1);

`ifdef EXT_WB_TIMEOUT_EN
    do_txn(32'h200, 32'h0, 4'h0, 1'b0, TO - 1, M_ACK, 32'h7777_0000, lat, rc, fs, rd, er, ca, cs, cw);
    check("to_edge_error", 32'(er), 32'h0);
    check("to_edge_rdata", rd, 32'h7777_0000);
    idle(1);
    do_txn(32'h204, 32'h0, 4'h0, 1'b0, 0, M_NONE, 32'h0, lat, rc, fs, rd, er, ca, cs, cw);
    check("to_error", 32'(er), 32'h1);
    check("to_rdata", rd, 32'h0);
    check("to_latency", 32'(lat), 32'(TO + 2));
    idle(1);
`endif

    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      d  = $urandom;
      s  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      f  = 1'($urandom_range(0, 1));
      w  = $urandom_range(0, WMAX);
      sd = $urandom;
      k  = $urandom_range(0, 9);
      mode = (k == 7) ? M_ERR : (k == 8) ? M_BOTH : M_ACK;
`ifdef EXT_WB_TIMEOUT_EN
      if (k == 9) mode = M_NONE;
`endif
      do_txn(a, d, s, f, w, mode, sd, lat, rc, fs, rd, er, ca, cs, cw);
      check("rnd_latency", 32'(lat), 32'(((mode == M_NONE) ? TO - 1 : w) + 3));
      idle($urandom_range(0, 2));
    end

    idle(1);
    @(posedge clk); #1;
    a = $urandom;
    ext_valid = 1'b1; ext_address = a; ext_write_data = 32'h0; ext_write_strobe = 4'h0;
    ext_instruction = 1'b0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    vc = cyc_n;
    set_model(vc, 100000, a, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    repeat (HANG) begin @(posedge clk); #1; end
    check("hang_cyc", 32'(wbm_cyc_o), 32'h1);
    @(negedge clk); #2;
    m_active = 1'b0;
    reset = 1'b1;
    #1;
    check("arst_cyc", 32'(wbm_cyc_o), 32'h0);
    check("arst_stb", 32'(wbm_stb_o), 32'h0);
    check("arst_ready", 32'(ext_ready), 32'h0);
    ext_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(10);

    do_txn(32'h0000_3000, 32'h0, 4'h0, 1'b1, 1, M_ACK, 32'h0F0F_1234, lat, rc, fs, rd, er, ca, cs, cw);
    check("post_rst_latency", 32'(lat), 32'd4);
    check("post_rst_rdata", rd, 32'h0F0F_1234);
    idle(3);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ext_wb_master_bridge.md
Name: ext_wb_master_bridge

Overview:
- Converts the core's ext_* memory port (valid/ready request, single outstanding access) into Wishbone B4 classic master cycles.
- Sits between the core's memory interface and the Wishbone interconnect in the user project area.
- Registers every request and response, so there is no combinational path from ext_* to wbm_*.
- Reports bus errors and, optionally, bus timeouts back to the core.

Parameters:
- ADDR_W, 32, width of ext_address and wbm_adr_o.
- DATA_W, 32, data width. Only 32 is supported.
- TIMEOUT_CYCLES, 255, wait-state limit before a forced error. Used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ext_valid  in  1  core request. Held with its fields stable until ext_ready.
- ext_instruction  in  1  request is an instruction fetch.
- ext_address  in  ADDR_W  byte address.
- ext_write_data  in  DATA_W  store data.
- ext_write_strobe  in  DATA_W/8  byte enables. Nonzero means write; all-zero means read.
- ext_ready  out  1  one-cycle completion pulse.
- ext_read_data  out  DATA_W  load/fetch data, valid while ext_ready is high.
- ext_error  out  1  qualifies ext_ready: the access faulted.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone cycle, strobe, write enable.
- wbm_sel_o  out  DATA_W/8  byte selects.
- wbm_adr_o  out  ADDR_W  word-aligned address.
- wbm_dat_o  out  DATA_W  write data.
- wbm_dat_i  in  DATA_W  read data.
- wbm_ack_i, wbm_err_i  in  1  slave acknowledge and error.
- fetch_tag_o  out  1  registered ext_instruction, for the interconnect.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Reset is asynchronous: asserting it mid-cycle drops cyc/stb immediately and discards the transaction. No ext_ready is ever issued for a discarded transaction.
- State machine:
  - IDLE: on ext_valid, latch the request. Set wbm_adr_o = {ext_address[ADDR_W-1:2], 2'b00}. wbm_we_o = |ext_write_strobe. wbm_sel_o = write ? strobe : all ones. Go to BUS. cyc/stb are asserted from the next cycle.
  - BUS: cyc = stb = 1; address, data and select held stable.
    - On wbm_ack_i or wbm_err_i: drop cyc/stb in the next cycle. Capture wbm_dat_i on a read; force 0 on a write or on error. Capture error = wbm_err_i. Go to DONE.
    - If ack and err are both high in the same cycle, err wins.
  - DONE: ext_ready = 1 for exactly one cycle, with ext_read_data and ext_error valid. Return to IDLE.
    - ext_valid sampled in DONE is ignored; the core may present its next request from the following cycle.
- Latency: a zero-wait-state slave gives ext_ready 3 cycles after ext_valid is first seen in IDLE. Each wait state adds one cycle.
- ack/err arriving while not in BUS are ignored.
- Single-outstanding only; there is no pipelining.
- ext_read_data holds its value outside DONE. ext_error is 0 outside DONE.

Optional Feature:
- Macro: EXT_WB_TIMEOUT_EN.
- When defined, an 8..16-bit wait counter clears on entry to BUS and increments each BUS cycle with no ack/err.
  - When the count reaches TIMEOUT_CYCLES, the bridge drops cyc/stb, goes to DONE with ext_error = 1 and read data 0, and clears the counter.
  - An ack in the same cycle as the limit is accepted as a normal completion.
- When undefined, the bridge waits in BUS indefinitely and the counter logic is absent.

Decomposition:
- Shared package cyberrio_bus_pkg holds:
  - the state enum (IDLE, BUS, DONE);
  - WORD_BYTES = 4 and SEL_ALL = 4'hF;
  - a request struct (address, data, sel, we, fetch).
- One sub-module, ext_wb_timeout_counter, instantiated only under EXT_WB_TIMEOUT_EN. Inputs: clear, enable. Output: expired.

Test Plan:
- Read, zero-wait slave: ext_valid, addr 0x0000_1006, strobe 0. Expect wbm_adr_o 0x0000_1004, sel F, we 0. Slave returns 0xDEAD_BEEF with ack on the first stb cycle. Expect ext_ready 3 cycles after valid, read data 0xDEAD_BEEF, ext_error 0.
- Write, 2 wait states: addr 0x20, data 0x1234_5678, strobe 4'b0011. Expect we 1, sel 3, dat_o 0x1234_5678 held stable for 3 stb cycles. Expect ext_ready 5 cycles after valid, read data 0.
- Error: slave raises ack and err in the same cycle on a fetch. Expect ext_error 1 with ext_ready, read data 0, fetch_tag_o 1 throughout BUS.
- Back-to-back requests: valid held across DONE for a new request. Expect the second cyc to assert no earlier than 2 cycles after ext_ready, and exactly one ext_ready per request.
- Reset during BUS (after cycle 1 of stb): expect cyc/stb and ext_ready low asynchronously, state IDLE, and no ext_ready after reset release.
- With EXT_WB_TIMEOUT_EN and TIMEOUT_CYCLES=8: a slave that never acks gives ext_ready with ext_error 1 after 8 BUS cycles, and cyc drops. Without the macro, cyc is still high after 1000 cycles.
